// File: rtl/uart_rx_pkg.sv
// Shared types, frame-configuration limits and frame-length helper for the UART receive bit timer.
package uart_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_PRESCALE = 4;
  localparam int unsigned MIN_DATA_LEN = 5;
  localparam int unsigned MAX_DATA_LEN = 8;

  // Start bit + data bits + optional parity + one or two stop bits (max 12).
  function automatic logic [3:0] frame_bits(input logic [3:0] data_len,
                                            input logic       par_en,
                                            input logic       stop2);
    return 4'd2 + data_len + {3'b000, par_en} + {3'b000, stop2};
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer_if.sv
// Control/status bundle between the RX FSM (master) and the bit timer (slave).
interface uart_rx_bit_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  start;
  logic                  abort;
  logic [PRESCALE_W-1:0] Prescale;
  logic [3:0]            data_len;
  logic                  par_en;
  logic                  stop2;
  logic                  busy;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sample_stb;
  logic                  sample_last;
  logic                  bit_end;
  logic                  frame_done;
  logic                  cfg_err;

  modport master (
    output start, abort, Prescale, data_len, par_en, stop2,
    input  busy, edge_cnt, bit_cnt, sample_stb, sample_last, bit_end, frame_done, cfg_err
  );

  modport slave (
    input  start, abort, Prescale, data_len, par_en, stop2,
    output busy, edge_cnt, bit_cnt, sample_stb, sample_last, bit_end, frame_done, cfg_err
  );
endinterface

// File: rtl/uart_sample_strobe_gen.sv
// Combinational decode of edge index into sample strobes; UART_RX_MAJORITY_EN widens the strobe to
// three edges around the bit centre for 2-of-3 voting. No state, no backpressure.
module uart_sample_strobe_gen
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  busy,
  output logic                  sample_stb,
  output logic                  sample_last
);

  logic [PRESCALE_W-1:0] centre;
  assign centre = prescale >> 1;

`ifdef UART_RX_MAJORITY_EN
  // Prescale >= 4 keeps centre-1 and centre+1 inside 0..P-1.
  always_comb begin
    sample_stb  = busy && ((edge_cnt == centre - 1'b1) ||
                           (edge_cnt == centre) ||
                           (edge_cnt == centre + 1'b1));
    sample_last = busy && (edge_cnt == centre + 1'b1);
  end
`else
  always_comb begin
    sample_stb  = busy && (edge_cnt == centre);
    sample_last = busy && (edge_cnt == centre);
  end
`endif

endmodule

// File: rtl/uart_rx_bit_timer.sv
// Oversampling bit/frame timer; all outputs registered, pulses aligned with the counters they describe.
// Sample placement selected by UART_RX_MAJORITY_EN; no backpressure, start accepted only when idle or at frame end.
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_rx_bit_timer_if.slave   bus
);

  state_t                state, nxt_state;
  logic [PRESCALE_W-1:0] edge_q, nxt_edge;
  logic [PRESCALE_W-1:0] presc_q, nxt_presc;
  logic [BIT_CNT_W-1:0]  bit_q, nxt_bit;
  logic [BIT_CNT_W-1:0]  nbits_q, nxt_nbits;
  logic                  stb_q, last_q, bend_q, fdone_q, cerr_q;
  logic                  nxt_stb, nxt_last, nxt_bend, nxt_fdone, nxt_cerr;
  logic                  cfg_ok, last_edge, frame_end, nxt_busy;

  assign cfg_ok = (bus.Prescale >= PRESCALE_W'(MIN_PRESCALE)) &&
                  (bus.data_len >= 4'(MIN_DATA_LEN)) &&
                  (bus.data_len <= 4'(MAX_DATA_LEN));

  assign last_edge = (edge_q == presc_q - 1'b1);
  assign frame_end = (state == RUN) && last_edge && (bit_q == nbits_q - 1'b1);

  // Priority: abort, then running frame, then (re)start at idle or on the final edge.
  always_comb begin
    nxt_state = IDLE;
    nxt_edge  = '0;
    nxt_bit   = '0;
    nxt_presc = presc_q;
    nxt_nbits = nbits_q;
    nxt_cerr  = 1'b0;
    if (bus.abort) begin
      nxt_state = IDLE;
    end else if ((state == RUN) && !frame_end) begin
      nxt_state = RUN;
      if (last_edge) begin
        nxt_bit = bit_q + 1'b1;
      end else begin
        nxt_edge = edge_q + 1'b1;
        nxt_bit  = bit_q;
      end
    end else if (bus.start) begin
      if (cfg_ok) begin
        nxt_state = RUN;
        nxt_presc = bus.Prescale;
        nxt_nbits = BIT_CNT_W'(frame_bits(bus.data_len, bus.par_en, bus.stop2));
      end else begin
        nxt_cerr = 1'b1;
      end
    end
  end

  // Pulses are decoded from next-cycle counters so the registered copies line up with them.
  assign nxt_busy  = (nxt_state == RUN);
  assign nxt_bend  = nxt_busy && (nxt_edge == nxt_presc - 1'b1);
  assign nxt_fdone = nxt_bend && (nxt_bit == nxt_nbits - 1'b1);

  uart_sample_strobe_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_strobe (
    .edge_cnt    (nxt_edge),
    .prescale    (nxt_presc),
    .busy        (nxt_busy),
    .sample_stb  (nxt_stb),
    .sample_last (nxt_last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      presc_q <= '0;
      nbits_q <= '0;
      stb_q   <= 1'b0;
      last_q  <= 1'b0;
      bend_q  <= 1'b0;
      fdone_q <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      edge_q  <= nxt_edge;
      bit_q   <= nxt_bit;
      presc_q <= nxt_presc;
      nbits_q <= nxt_nbits;
      stb_q   <= nxt_stb;
      last_q  <= nxt_last;
      bend_q  <= nxt_bend;
      fdone_q <= nxt_fdone;
      cerr_q  <= nxt_cerr;
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.sample_stb  = stb_q;
  assign bus.sample_last = last_q;
  assign bus.bit_end     = bend_q;
  assign bus.frame_done  = fdone_q;
  assign bus.cfg_err     = cerr_q;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed plus randomized bench for uart_rx_bit_timer against a frame-position reference model.
module tb_uart_rx_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;
  localparam int OW = PW + BW + 6;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_bit_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

  uart_rx_bit_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a running frame is a position k in 0..N*P-1 counted from its first cycle.
  bit m_run  = 1'b0;
  bit m_cerr = 1'b0;
  int m_k = 0;
  int m_p = 1;
  int m_n = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] observed();
    return {bus.busy, bus.edge_cnt, bus.bit_cnt, bus.sample_stb, bus.sample_last,
            bus.bit_end, bus.frame_done, bus.cfg_err};
  endfunction

  function automatic logic [OW-1:0] expected();
    logic [PW-1:0] e;
    logic [BW-1:0] b;
    logic stb, lst, be, fd;
    int ph, c;
    e = '0; b = '0; stb = 0; lst = 0; be = 0; fd = 0;
    if (m_run) begin
      ph  = m_k % m_p;
      c   = m_p / 2;
      e   = PW'(ph);
      b   = BW'(m_k / m_p);
      stb = MAJ ? (ph >= c - 1 && ph <= c + 1) : (ph == c);
      lst = MAJ ? (ph == c + 1) : (ph == c);
      be  = (ph == m_p - 1);
      fd  = (m_k == m_p * m_n - 1);
    end
    return {m_run, e, b, stb, lst, be, fd, m_cerr};
  endfunction

  task automatic model_step();
    bit legal;
    legal = (bus.Prescale >= 4) && (bus.data_len >= 5) && (bus.data_len <= 8);
    m_cerr = 1'b0;
    if (bus.abort) begin
      m_run = 1'b0; m_k = 0;
    end else if (m_run && m_k < m_p * m_n - 1) begin
      m_k++;
    end else if (bus.start && legal) begin
      m_run = 1'b1; m_k = 0;
      m_p = int'(bus.Prescale);
      m_n = 2 + int'(bus.data_len) + int'(bus.par_en) + int'(bus.stop2);
    end else begin
      m_run = 1'b0; m_k = 0;
      m_cerr = bus.start;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check("cycle", 32'(observed()), 32'(expected()));
  endtask

  task automatic set_cfg(input int p, input int dl, input bit par, input bit s2);
    bus.Prescale = PW'(p);
    bus.data_len = 4'(dl);
    bus.par_en   = par;
    bus.stop2    = s2;
  endtask

  int fd_at, fd_bit, fd_edge, be_cnt, busy_cnt, gap_cnt;
  logic [31:0] stb_mask, last_mask;

  initial begin
    bus.start = 0; bus.abort = 0;
    set_cfg(8, 8, 0, 0);
    #12;
    check("reset_outputs", 32'(observed()), 32'd0);
    #5 RST = 1'b1;
    tick(); tick();

    // 8N1 at P=8: ten bits, 80 cycles
    fd_at = 0; fd_bit = 0; fd_edge = 0; be_cnt = 0; busy_cnt = 0;
    for (int i = 1; i <= 90; i++) begin
      bus.start = (i == 1);
      tick();
      if (bus.frame_done) begin fd_at = i; fd_bit = int'(bus.bit_cnt); fd_edge = int'(bus.edge_cnt); end
      be_cnt += int'(bus.bit_end);
      busy_cnt += int'(bus.busy);
    end
    check("t1_frame_done_cycle", fd_at, 80);
    check("t1_frame_done_bit", fd_bit, 9);
    check("t1_frame_done_edge", fd_edge, 7);
    check("t1_bit_end_count", be_cnt, 10);
    check("t1_busy_cycles", busy_cnt, 80);

    // 7E2 at P=16: eleven bits, 176 cycles
    set_cfg(16, 7, 1, 1);
    fd_at = 0; stb_mask = 0; last_mask = 0;
    for (int i = 1; i <= 190; i++) begin
      bus.start = (i == 1);
      tick();
      if (bus.frame_done) fd_at = i;
      if (bus.bit_cnt == 3 && bus.sample_stb) stb_mask |= 32'd1 << bus.edge_cnt;
      if (bus.bit_cnt == 3 && bus.sample_last) last_mask |= 32'd1 << bus.edge_cnt;
    end
    check("t2_frame_done_cycle", fd_at, 176);
    check("t2_strobe_edges", stb_mask, MAJ ? 32'h380 : 32'h100);
    check("t2_last_edge", last_mask, MAJ ? 32'h200 : 32'h100);

    // Illegal configurations
    set_cfg(3, 8, 0, 0);
    bus.start = 1; tick(); bus.start = 0;
    check("t3_cfg_err_p3", bus.cfg_err, 1);
    check("t3_busy_p3", bus.busy, 0);
    tick();
    check("t3_cfg_err_clears", bus.cfg_err, 0);
    set_cfg(8, 9, 0, 0);
    bus.start = 1; tick(); bus.start = 0;
    check("t3_cfg_err_dl9", bus.cfg_err, 1);
    check("t3_busy_dl9", bus.busy, 0);
    tick();

    // Abort with simultaneous start at bit 4, edge 2
    set_cfg(8, 8, 0, 0);
    bus.start = 1; tick(); bus.start = 0;
    repeat (34) tick();
    check("t4_pos_bit", bus.bit_cnt, 4);
    check("t4_pos_edge", bus.edge_cnt, 2);
    bus.abort = 1; bus.start = 1; tick(); bus.abort = 0; bus.start = 0;
    check("t4_abort_state", {bus.busy, bus.edge_cnt, bus.bit_cnt, bus.frame_done}, 0);
    repeat (5) tick();
    check("t4_stays_idle", bus.busy, 0);

    // Back-to-back frames with a mid-frame Prescale change (P=6, 5N1 -> 42 cycles)
    set_cfg(6, 5, 0, 0);
    gap_cnt = 0;
    bus.start = 1; tick(); bus.start = 0;
    repeat (10) begin tick(); gap_cnt += int'(!bus.busy); end
    bus.Prescale = PW'(10);
    repeat (31) begin tick(); gap_cnt += int'(!bus.busy); end
    check("t5_frame1_done", bus.frame_done, 1);
    bus.start = 1; tick(); bus.start = 0;
    check("t5_frame2_start", {bus.busy, bus.edge_cnt, bus.bit_cnt}, {1'b1, {PW{1'b0}}, {BW{1'b0}}});
    repeat (9) tick();
    check("t5_frame2_p10", {bus.bit_end, bus.edge_cnt}, {1'b1, PW'(9)});
    check("t5_no_gap", gap_cnt, 0);
    repeat (65) tick();

    // Asynchronous reset mid-frame
    set_cfg(8, 8, 0, 0);
    bus.start = 1; tick(); bus.start = 0;
    repeat (40) tick();
    check("t6_pos_bit", bus.bit_cnt, 5);
    #2 RST = 1'b0;
    #1 check("t6_reset_outputs", 32'(observed()), 32'd0);
    m_run = 0; m_k = 0; m_cerr = 0;
    #3 RST = 1'b1;
    repeat (5) tick();
    check("t6_idle_after_reset", bus.busy, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 15) == 0);
      if (m_run && m_k == m_p * m_n - 1 && $urandom_range(0, 1) == 1) bus.start = 1;
      bus.abort = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0)
        set_cfg(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 12)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(5, 8)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    bus.start = 0; bus.abort = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
